iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width taken from B[SHW-1:0].
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  4  operation code (see REQ-012).
REQ-008 SHALL have ports A, B  input  XLEN  operands.
REQ-009 SHALL have port out_valid  output  1  Result/Zero hold a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have ports Result  output  XLEN  and Zero  output  1 (Zero = Result==0).

Function
REQ-012 Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, 1 if A<B), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low XLEN bits), 11 DIVU, 12 REMU; 13-15 produce Result 0 with single-cycle latency.
REQ-013 States IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-014 Accept when in_valid&&in_ready on a clock edge; A, B, op captured into internal registers; later input changes ignored.
REQ-015 Ops 0-9 and 13-15: IDLE->DONE on accept; out_valid asserted the next cycle (latency 1).
REQ-016 Ops 10-12: IDLE->BUSY on accept; BUSY runs exactly XLEN iterations, then ->DONE; out_valid asserted XLEN+1 cycles after accept.
REQ-017 MUL: shift-add, one multiplier bit per cycle; result modulo 2^XLEN.
REQ-018 DIVU/REMU: restoring division, one quotient bit per cycle; unsigned operands.
REQ-019 Divide by zero: DIVU Result all-ones, REMU Result = A; still takes XLEN+1 cycles.
REQ-020 Shifts use B[SHW-1:0] only; SRA replicates A[XLEN-1].
REQ-021 ADD/SUB wrap modulo 2^XLEN; no overflow output.
REQ-022 DONE: Result/Zero held stable while out_valid=1 && out_ready=0.
REQ-023 DONE->IDLE on out_valid&&out_ready; out_valid low next cycle; no back-to-back accept in that same edge (in_ready low in DONE).
REQ-024 out_ready ignored outside DONE; in_valid ignored outside IDLE.
REQ-025 Zero derived combinationally from registered Result.

Reset
REQ-026 rst_n=0 sampled at an edge forces IDLE, in_ready=1 next cycle, out_valid=0, Result=0, Zero=1, iteration counter=0.
REQ-027 Reset mid-BUSY or in DONE SHALL abandon the operation; no result ever presented for it.
REQ-028 Reset SHALL dominate simultaneous in_valid or out_ready.

Structure
REQ-029 Shared package iter_alu_pkg SHALL hold op-code localparams and the state enumeration.
REQ-030 One sub-module iter_muldiv SHALL implement the iterative MUL/DIVU/REMU datapath (start, done, counter, accumulators); single-cycle ops stay in iter_alu.
REQ-031 Only registered outputs: in_ready, out_valid, Result.

Verification
REQ-032 ADD A=32'h7FFFFFFF,B=1, out_ready=1 -> out_valid cycle+1, Result=32'h80000000, Zero=0.
REQ-033 SLT A=32'hFFFFFFFF,B=0 -> Result=1; SLTU same operands -> Result=0; SRA A=32'h80000000,B=32'h21 -> Result=32'hC0000000.
REQ-034 MUL A=7,B=6 -> out_valid exactly 33 cycles after accept, Result=42; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 DIVU A=5,B=0 -> Result=32'hFFFFFFFF; REMU A=5,B=0 -> Result=5, Zero=0.
REQ-036 Backpressure: SUB 5-5 with out_ready=0 for 10 cycles -> Result=0, Zero=1 stable, in_ready=0; release -> IDLE next cycle.
REQ-037 rst_n=0 at BUSY iteration 10 of DIVU -> next cycle in_ready=1, out_valid=0; new ADD 1+1 returns 2 with no stale result.

Source files
------------

// File: rtl/iter_alu_pkg.sv
// iter_alu_pkg: op codes, state encoding and op classification shared by the iterative ALU
package iter_alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic is_iter(input logic [3:0] o);
    return o == OP_MUL || o == OP_DIVU || o == OP_REMU;
  endfunction
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: one-bit-per-cycle shift-add multiplier and restoring divider
module iter_muldiv import iter_alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN);
  logic            busy;
  logic [CW-1:0]   cnt;
  logic [3:0]      op_q;
  logic [XLEN-1:0] x, y, acc, x_n, y_n, acc_n;
  logic [XLEN:0]   t, diff;
  logic            mul, ge;
  always_comb begin
    mul   = op_q == OP_MUL;
    t     = {acc, x[XLEN-1]};
    diff  = t - {1'b0, y};
    ge    = !diff[XLEN];
    acc_n = mul ? acc + (y[0] ? x : '0) : ge ? diff[XLEN-1:0] : t[XLEN-1:0];
    x_n   = mul ? x << 1 : {x[XLEN-2:0], ge};
    y_n   = mul ? y >> 1 : y;
    done  = busy && cnt == CW'(XLEN - 1);
    res   = op_q == OP_DIVU ? x_n : acc_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      op_q <= '0;
      x    <= '0;
      y    <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      op_q <= op;
      x    <= a;
      y    <= b;
      acc  <= '0;
    end else if (busy) begin
      busy <= !done;
      cnt  <= cnt + CW'(1);
      x    <= x_n;
      y    <= y_n;
      acc  <= acc_n;
    end
  end
endmodule

// File: rtl/iter_alu.sv
// iter_alu: valid/ready ALU with single-cycle logic ops and iterative MUL/DIVU/REMU
module iter_alu import iter_alu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);
  state_t          state, state_n;
  logic [XLEN-1:0] alu, res_n, md_res;
  logic [SHW-1:0]  sh;
  logic            start, md_done;
  iter_muldiv #(.XLEN(XLEN)) u_md (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(A), .b(B),
    .done(md_done), .res(md_res)
  );
  always_comb begin
    sh  = B[SHW-1:0];
    alu = '0;
    case (op)
      OP_ADD:  alu = A + B;
      OP_SUB:  alu = A - B;
      OP_AND:  alu = A & B;
      OP_OR:   alu = A | B;
      OP_XOR:  alu = A ^ B;
      OP_SLT:  alu = XLEN'($signed(A) < $signed(B));
      OP_SLTU: alu = XLEN'(A < B);
      OP_SLL:  alu = A << sh;
      OP_SRL:  alu = A >> sh;
      OP_SRA:  alu = $unsigned($signed(A) >>> sh);
      default: alu = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    res_n   = Result;
    start   = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        start   = is_iter(op);
        state_n = start ? BUSY : DONE;
        res_n   = start ? Result : alu;
      end
      BUSY: if (md_done) begin
        state_n = DONE;
        res_n   = md_res;
      end
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Result    <= '0;
    end else begin
      state     <= state_n;
      in_ready  <= state_n == IDLE;
      out_valid <= state_n == DONE;
      Result    <= res_n;
    end
  end
  assign Zero = Result == '0;
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed vector table plus handshake/reset sequences for iter_alu
module tb_iter_alu;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, Zero;
  logic [3:0]  op;
  logic [31:0] A, B, Result;
  int          npass = 0, ntot = 0;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        z;
    int          lat;
  } vec_t;
  vec_t vecs[19];
  iter_alu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Zero(Zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] r, output logic z, output int lat);
    @(negedge clk);
    op = o;
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    op = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = Result;
    z = Zero;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
  initial begin
    logic [31:0] r;
    logic        z;
    int          lat, seen;
    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1};
    vecs[1]  = '{4'd1,  32'h5,        32'h5,        32'h0,        1'b1, 1};
    vecs[2]  = '{4'd1,  32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1};
    vecs[3]  = '{4'd2,  32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1};
    vecs[4]  = '{4'd3,  32'hF0F0,     32'h0F0F,     32'hFFFF,     1'b0, 1};
    vecs[5]  = '{4'd4,  32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1};
    vecs[6]  = '{4'd5,  32'hFFFFFFFF, 32'h0,        32'h1,        1'b0, 1};
    vecs[7]  = '{4'd6,  32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1};
    vecs[8]  = '{4'd7,  32'h1,        32'h24,       32'h10,       1'b0, 1};
    vecs[9]  = '{4'd8,  32'h80000000, 32'h1F,       32'h1,        1'b0, 1};
    vecs[10] = '{4'd9,  32'h80000000, 32'h21,       32'hC0000000, 1'b0, 1};
    vecs[11] = '{4'd13, 32'h5,        32'h5,        32'h0,        1'b1, 1};
    vecs[12] = '{4'd10, 32'h7,        32'h6,        32'd42,       1'b0, 33};
    vecs[13] = '{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 33};
    vecs[14] = '{4'd11, 32'd100,      32'd7,        32'd14,       1'b0, 33};
    vecs[15] = '{4'd12, 32'd100,      32'd7,        32'd2,        1'b0, 33};
    vecs[16] = '{4'd11, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 33};
    vecs[17] = '{4'd12, 32'd5,        32'd0,        32'd5,        1'b0, 33};
    vecs[18] = '{4'd11, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 1'b0, 33};
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    op = 4'd0;
    A = 32'd3;
    B = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {in_ready, out_valid, Zero, Result}, {1'b1, 1'b0, 1'b1, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat);
      chk($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].res));
      chk($sformatf("vec%0d_zero", i), 64'(z), 64'(vecs[i].z));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end
    @(negedge clk);
    op = 4'd1;
    A = 32'd5;
    B = 32'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    op = 4'd0;
    A = 32'd1;
    B = 32'd1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold%0d", i), {out_valid, in_ready, Zero, Result}, {1'b1, 1'b0, 1'b1, 32'h0});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release", {out_valid, in_ready}, {1'b0, 1'b1});
    @(negedge clk);
    op = 4'd11;
    A = 32'd100;
    B = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("busy_before_rst", {in_ready, out_valid}, {1'b0, 1'b0});
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rst_mid_busy", {in_ready, out_valid, Zero, Result}, {1'b1, 1'b0, 1'b1, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("no_stale_result", 64'(seen), 64'd0);
    run(4'd0, 32'd1, 32'd1, r, z, lat);
    chk("post_rst_add", {z, r}, {1'b0, 32'd2});
    chk("post_rst_add_lat", 64'(lat), 64'd1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
